// File: rtl/bitcoin_pkg.sv
// Shared definitions for the bitcoin hashing datapath and its post-processing.
// Holds the default nonce count, the result-scan FSM state encoding and the
// read latency of the shared single-port hash memory.
package bitcoin_pkg;

  // Number of consecutive H0 words produced per hashing run.
  localparam int NUM_NONCE_DEFAULT = 16;

  // Cycles from address presentation to data on mem_read_data.
  localparam int MEM_RD_LAT = 1;

  // Starting value for a running minimum, so any real word can replace it.
  localparam logic [31:0] HASH_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    FINISH = 2'd2
  } scan_state_e;

endpackage

// File: rtl/nonce_result_scan_min_tracker.sv
// min_tracker: registered running minimum with the index where it was seen.
//   clk, reset : clock and synchronous active-high reset
//   clr        : restart tracking (minimum to all-ones, index to 0)
//   valid      : present value/idx this cycle
//   value, idx : candidate word and its index
//   min_value  : smallest value seen since the last clr/reset
//   min_idx    : index of that value; strict less-than keeps the earliest tie
module min_tracker
  import bitcoin_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             valid,
  input  logic [31:0]      value,
  input  logic [IDX_W-1:0] idx,
  output logic [31:0]      min_value,
  output logic [IDX_W-1:0] min_idx
);

  logic [31:0]      min_value_q, min_value_d;
  logic [IDX_W-1:0] min_idx_q, min_idx_d;

  always_comb begin
    min_value_d = min_value_q;
    min_idx_d   = min_idx_q;
    if (clr) begin
      min_value_d = HASH_MAX;
      min_idx_d   = '0;
    end else if (valid && (value < min_value_q)) begin
      min_value_d = value;
      min_idx_d   = idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      min_value_q <= HASH_MAX;
      min_idx_q   <= '0;
    end else begin
      min_value_q <= min_value_d;
      min_idx_q   <= min_idx_d;
    end
  end

  assign min_value = min_value_q;
  assign min_idx   = min_idx_q;

endmodule

// File: rtl/nonce_result_scan.sv
// nonce_result_scan: reads NUM_NONCE H0 words back from the hash memory,
// flags those below a difficulty target and tracks the smallest one.
//   clk, reset          : sole clock, synchronous active-high reset
//   start               : one-cycle scan request, honoured only in IDLE
//   hash_addr, target   : base address of nonce 0 and threshold, latched at start
//   done                : one-cycle pulse, results final in this cycle
//   found, hit_mask     : any hit / per-nonce hit flags (H0 < target)
//   best_nonce/best_hash: index and value of the minimum H0
//   mem_*               : read-only single-port memory client
//   dbg_state           : current FSM state
//
// Handshake: start is a single-cycle request with no acknowledge; it is only
// accepted in IDLE, and requests in READ/FINISH are dropped, not queued.
module nonce_result_scan
  import bitcoin_pkg::*;
#(
  parameter int NUM_NONCE = NUM_NONCE_DEFAULT,
  parameter int IDX_W     = $clog2(NUM_NONCE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [15:0]          hash_addr,
  input  logic [31:0]          target,
  output logic                 done,
  output logic                 found,
  output logic [NUM_NONCE-1:0] hit_mask,
  output logic [IDX_W-1:0]     best_nonce,
  output logic [31:0]          best_hash,
  output logic                 mem_clk,
  output logic                 mem_we,
  output logic [15:0]          mem_addr,
  input  logic [31:0]          mem_read_data,
  output logic [1:0]           dbg_state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NONCE - 1);

  scan_state_e          state_q, state_d;
  logic [15:0]          base_q, base_d;
  logic [31:0]          target_q, target_d;
  logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]     cap_idx_q, cap_idx_d;
  logic [NUM_NONCE-1:0] hit_mask_q, hit_mask_d;
  logic                 found_q, found_d;
  // One stage per cycle of memory latency: a READ cycle's address returns
  // data MEM_RD_LAT edges later, so the flag marks when a word is capturable.
  logic [MEM_RD_LAT-1:0] cap_pipe_q;

  logic start_acc;
  logic cap_v;
  logic word_hit;

  assign cap_v    = (state_q == READ) && cap_pipe_q[MEM_RD_LAT-1];
  assign word_hit = (mem_read_data < target_q);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    target_d   = target_q;
    rd_idx_d   = rd_idx_q;
    cap_idx_d  = cap_idx_q;
    hit_mask_d = hit_mask_q;
    found_d    = found_q;
    start_acc  = 1'b0;
    done       = 1'b0;
    mem_addr   = base_q + 16'(rd_idx_q);

    case (state_q)
      IDLE: begin
        mem_addr = hash_addr;
        if (start) begin
          start_acc  = 1'b1;
          base_d     = hash_addr;
          target_d   = target;
          rd_idx_d   = '0;
          cap_idx_d  = '0;
          hit_mask_d = '0;
          found_d    = 1'b0;
          state_d    = READ;
        end
      end
      READ: begin
        // The address counter runs ahead of capture and parks on the last word.
        if (rd_idx_q != LAST_IDX) rd_idx_d = rd_idx_q + 1'b1;
        if (cap_v) begin
          hit_mask_d[cap_idx_q] = word_hit;
          found_d               = found_q | word_hit;
          cap_idx_d             = cap_idx_q + 1'b1;
          if (cap_idx_q == LAST_IDX) state_d = FINISH;
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      target_q   <= '0;
      rd_idx_q   <= '0;
      cap_idx_q  <= '0;
      hit_mask_q <= '0;
      found_q    <= 1'b0;
      cap_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      target_q   <= target_d;
      rd_idx_q   <= rd_idx_d;
      cap_idx_q  <= cap_idx_d;
      hit_mask_q <= hit_mask_d;
      found_q    <= found_d;
      if (start_acc) begin
        cap_pipe_q <= '0;
      end else begin
        cap_pipe_q[0] <= (state_q == READ);
        for (int i = 1; i < MEM_RD_LAT; i++) cap_pipe_q[i] <= cap_pipe_q[i-1];
      end
    end
  end

  min_tracker #(.IDX_W(IDX_W)) u_min (
    .clk       (clk),
    .reset     (reset),
    .clr       (start_acc),
    .valid     (cap_v),
    .value     (mem_read_data),
    .idx       (cap_idx_q),
    .min_value (best_hash),
    .min_idx   (best_nonce)
  );

  assign found     = found_q;
  assign hit_mask  = hit_mask_q;
  assign mem_clk   = clk;
  assign mem_we    = 1'b0;
  assign dbg_state = state_q;

endmodule
